// File: rtl/layernorm_row_sequencer.sv
// Batch-to-row command sequencer for the LayerNorm engine: expands one batch
// command into per-row engine commands with strided addresses and a done watchdog.
module layernorm_row_sequencer #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              batch_valid,
    output logic              batch_ready,
    input  logic [15:0]       batch_rows,
    input  logic [15:0]       batch_length,
    input  logic [ADDR_W-1:0] batch_src_base,
    input  logic [ADDR_W-1:0] batch_src_stride,
    input  logic [ADDR_W-1:0] batch_dst_base,
    input  logic [ADDR_W-1:0] batch_dst_stride,
    input  logic [ADDR_W-1:0] batch_gamma_base,
    input  logic [ADDR_W-1:0] batch_beta_base,
    output logic              ln_cmd_valid,
    input  logic              ln_cmd_ready,
    output logic [15:0]       ln_length,
    output logic [ADDR_W-1:0] ln_src_base,
    output logic [ADDR_W-1:0] ln_dst_base,
    output logic [ADDR_W-1:0] ln_gamma_base,
    output logic [ADDR_W-1:0] ln_beta_base,
    input  logic              ln_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       rows_done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    rows_q;
    logic [CNT_W-1:0]    row_idx;
    logic [ADDR_W-1:0]   src_stride_q;
    logic [ADDR_W-1:0]   dst_stride_q;
    logic [WDOG_W-1:0]   wdog;

    logic accept_c;
    logic last_row_c;
    logic zero_batch_c;

    assign accept_c     = batch_valid && batch_ready;
    assign last_row_c   = (row_idx == rows_q - CNT_W'(1));
    assign zero_batch_c = (batch_rows == '0) || (batch_length == '0);

    // Sequencer FSM; the ln_* payload registers double as the current row addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            batch_ready   <= 1'b1;
            busy          <= 1'b0;
            ln_cmd_valid  <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rows_done     <= '0;
            ln_length     <= '0;
            ln_src_base   <= '0;
            ln_dst_base   <= '0;
            ln_gamma_base <= '0;
            ln_beta_base  <= '0;
            rows_q        <= '0;
            row_idx       <= '0;
            src_stride_q  <= '0;
            dst_stride_q  <= '0;
            wdog          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        ln_length     <= batch_length;
                        ln_src_base   <= batch_src_base;
                        ln_dst_base   <= batch_dst_base;
                        ln_gamma_base <= batch_gamma_base;
                        ln_beta_base  <= batch_beta_base;
                        src_stride_q  <= batch_src_stride;
                        dst_stride_q  <= batch_dst_stride;
                        rows_q        <= batch_rows;
                        row_idx       <= '0;
                        rows_done     <= '0;
                        wdog          <= '0;
                        batch_ready   <= 1'b0;
                        busy          <= 1'b1;
                        if (zero_batch_c) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state        <= S_ISSUE;
                            ln_cmd_valid <= 1'b1;
                            err          <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ln_cmd_ready) begin
                        ln_cmd_valid <= 1'b0;
                        wdog         <= '0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A completion arriving on the expiry cycle still counts as success.
                    if (ln_done) begin
                        rows_done <= rows_done + CNT_W'(1);
                        if (last_row_c) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (WDOG_EN && (wdog == WDOG_LAST)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                S_NEXT: begin
                    ln_src_base  <= ln_src_base + src_stride_q;
                    ln_dst_base  <= ln_dst_base + dst_stride_q;
                    row_idx      <= row_idx + CNT_W'(1);
                    ln_cmd_valid <= 1'b1;
                    state        <= S_ISSUE;
                end
                S_DONE: begin
                    batch_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    ln_cmd_valid <= 1'b0;
                    batch_ready  <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layernorm_row_sequencer.sv
// Scoreboard bench for layernorm_row_sequencer: a behavioural engine records every
// command handshake; scenario tasks compare those against expected per-row commands.
module tb_layernorm_row_sequencer;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned TIMEOUT_CYC = 64;

    typedef struct packed {
        logic [15:0]       len;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] gamma;
        logic [ADDR_W-1:0] beta;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              batch_valid;
    logic              batch_ready;
    logic [15:0]       batch_rows;
    logic [15:0]       batch_length;
    logic [ADDR_W-1:0] batch_src_base;
    logic [ADDR_W-1:0] batch_src_stride;
    logic [ADDR_W-1:0] batch_dst_base;
    logic [ADDR_W-1:0] batch_dst_stride;
    logic [ADDR_W-1:0] batch_gamma_base;
    logic [ADDR_W-1:0] batch_beta_base;
    logic              ln_cmd_valid;
    logic              ln_cmd_ready;
    logic [15:0]       ln_length;
    logic [ADDR_W-1:0] ln_src_base;
    logic [ADDR_W-1:0] ln_dst_base;
    logic [ADDR_W-1:0] ln_gamma_base;
    logic [ADDR_W-1:0] ln_beta_base;
    logic              ln_done;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       rows_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    cmd_t sb[$];
    int   rd_idx = 0;

    // Written only by the engine process.
    cmd_t obs[256];
    int   hs_cyc[256];
    int   hs_count = 0;
    int   lnd_cyc[256];
    int   lnd_count = 0;

    // Engine controls, written only by the main sequence.
    int   eng_delay  = 2;
    bit   eng_hang   = 1'b0;
    int   inject_req = 0;

    layernorm_row_sequencer #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .batch_valid      (batch_valid),
        .batch_ready      (batch_ready),
        .batch_rows       (batch_rows),
        .batch_length     (batch_length),
        .batch_src_base   (batch_src_base),
        .batch_src_stride (batch_src_stride),
        .batch_dst_base   (batch_dst_base),
        .batch_dst_stride (batch_dst_stride),
        .batch_gamma_base (batch_gamma_base),
        .batch_beta_base  (batch_beta_base),
        .ln_cmd_valid     (ln_cmd_valid),
        .ln_cmd_ready     (ln_cmd_ready),
        .ln_length        (ln_length),
        .ln_src_base      (ln_src_base),
        .ln_dst_base      (ln_dst_base),
        .ln_gamma_base    (ln_gamma_base),
        .ln_beta_base     (ln_beta_base),
        .ln_done          (ln_done),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .rows_done        (rows_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural engine: acts just after each falling edge, pulses ln_done eng_delay cycles after a command.
    initial begin : engine
        bit pend;
        int pend_cnt;
        int inj_seen;
        pend     = 1'b0;
        pend_cnt = 0;
        inj_seen = 0;
        ln_done  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            ln_done = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (inject_req != inj_seen) begin
                    inj_seen = inject_req;
                    ln_done  = 1'b1;
                end
                if (pend) begin
                    if (pend_cnt == 0) begin
                        ln_done = 1'b1;
                        pend    = 1'b0;
                        lnd_cyc[lnd_count % 256] = cyc;
                        lnd_count++;
                    end else begin
                        pend_cnt--;
                    end
                end
                if (ln_cmd_valid && ln_cmd_ready) begin
                    obs[hs_count % 256]    = {ln_length, ln_src_base, ln_dst_base, ln_gamma_base, ln_beta_base};
                    hs_cyc[hs_count % 256] = cyc;
                    hs_count++;
                    if (!eng_hang) begin
                        pend     = 1'b1;
                        pend_cnt = eng_delay;
                    end
                end
            end
        end
    end

    // Drives one batch for one cycle, queues the expected row commands, scrambles the fields afterwards.
    task automatic send_batch(input logic [15:0] rows, input logic [15:0] len,
                              input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] ss,
                              input logic [ADDR_W-1:0] dst, input logic [ADDR_W-1:0] ds,
                              input logic [ADDR_W-1:0] g, input logic [ADDR_W-1:0] b,
                              output int acc);
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] d;
        s = src;
        d = dst;
        if (rows != 16'd0 && len != 16'd0) begin
            for (int r = 0; r < int'(rows); r++) begin
                sb.push_back({len, s, d, g, b});
                s = s + ss;
                d = d + ds;
            end
        end
        batch_rows       = rows;
        batch_length     = len;
        batch_src_base   = src;
        batch_src_stride = ss;
        batch_dst_base   = dst;
        batch_dst_stride = ds;
        batch_gamma_base = g;
        batch_beta_base  = b;
        batch_valid      = 1'b1;
        @(negedge clk);
        batch_valid      = 1'b0;
        batch_rows       = 16'h0007;
        batch_length     = 16'h0033;
        batch_src_base   = 16'hDEAD;
        batch_src_stride = 16'h0101;
        batch_dst_base   = 16'hBEEF;
        batch_dst_stride = 16'h0202;
        batch_gamma_base = 16'h1111;
        batch_beta_base  = 16'h2222;
        acc = cyc;
    endtask

    task automatic wait_done(input int budget, output bit got, output int at);
        got = 1'b0;
        at  = -1;
        for (int i = 0; i < budget && !got; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                at  = cyc;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ln_cmd_valid, done, err, busy, batch_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00001", {ln_cmd_valid, done, err, busy, batch_ready});
        end
        checks++;
        if (rows_done !== 16'd0) begin
            failures++;
            $display("FAIL reset_rows_done got=%0d want=0", rows_done);
        end
        checks++;
        if ({ln_length, ln_src_base, ln_dst_base, ln_gamma_base, ln_beta_base} !== 80'd0) begin
            failures++;
            $display("FAIL reset_payload got=%h want=0", {ln_length, ln_src_base, ln_dst_base, ln_gamma_base, ln_beta_base});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multi_row();
        int   acc, at, hs0, lnd0;
        bit   got;
        cmd_t e;
        hs0 = hs_count;
        lnd0 = lnd_count;
        eng_delay = 3;
        ln_cmd_ready = 1'b1;
        send_batch(16'd3, 16'd8, 16'h0100, 16'h0010, 16'h0400, 16'h0020, 16'h0800, 16'h0900, acc);
        checks++;
        if (ln_cmd_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL multi_first_cmd valid=%b busy=%b want 1/1", ln_cmd_valid, busy);
        end
        // A second batch offered while busy must be ignored.
        batch_valid = 1'b1;
        batch_rows = 16'd5;
        @(negedge clk);
        checks++;
        if (batch_ready !== 1'b0) begin
            failures++;
            $display("FAIL multi_ready_busy got=%b want=0", batch_ready);
        end
        batch_valid = 1'b0;
        wait_done(200, got, at);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL multi_done_timeout got=0 want=1");
        end
        checks++;
        if (err !== 1'b0 || rows_done !== 16'd3) begin
            failures++;
            $display("FAIL multi_status err=%b rows_done=%0d want 0/3", err, rows_done);
        end
        checks++;
        if (hs_count - hs0 != 3 || lnd_count - lnd0 != 3) begin
            failures++;
            $display("FAIL multi_cmd_count got=%0d/%0d want=3/3", hs_count - hs0, lnd_count - lnd0);
        end else begin
            checks++;
            if (hs_cyc[(hs0 + 1) % 256] != lnd_cyc[lnd0 % 256] + 2) begin
                failures++;
                $display("FAIL multi_next_latency got=%0d want=%0d", hs_cyc[(hs0 + 1) % 256], lnd_cyc[lnd0 % 256] + 2);
            end
            checks++;
            if (at != lnd_cyc[(lnd0 + 2) % 256] + 1) begin
                failures++;
                $display("FAIL multi_done_latency got=%0d want=%0d", at, lnd_cyc[(lnd0 + 2) % 256] + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || rows_done !== 16'd3) begin
            failures++;
            $display("FAIL multi_done_pulse done=%b err=%b rows_done=%0d want 0/0/3", done, err, rows_done);
        end
        while (rd_idx < hs_count) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL multi_cmd extra got=%h want=none", obs[rd_idx % 256]);
            end else begin
                e = sb.pop_front();
                if (obs[rd_idx % 256] !== e) begin
                    failures++;
                    $display("FAIL multi_cmd got=%h want=%h", obs[rd_idx % 256], e);
                end
            end
            rd_idx++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL multi_cmd_missing got=%0d pending want=0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        int   acc, at, hs0, vcount;
        bit   got;
        cmd_t e;
        cmd_t want;
        want = {16'd16, 16'h2000, 16'h5000, 16'h0A00, 16'h0B00};
        hs0 = hs_count;
        vcount = 0;
        eng_delay = 2;
        ln_cmd_ready = 1'b0;
        send_batch(16'd1, 16'd16, 16'h2000, 16'h0040, 16'h5000, 16'h0080, 16'h0A00, 16'h0B00, acc);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            if (ln_cmd_valid === 1'b1) vcount++;
            checks++;
            if ({ln_length, ln_src_base, ln_dst_base, ln_gamma_base, ln_beta_base} !== want) begin
                failures++;
                $display("FAIL bp_payload cyc%0d got=%h want=%h", i, {ln_length, ln_src_base, ln_dst_base, ln_gamma_base, ln_beta_base}, want);
            end
            if (i == 5) ln_cmd_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (vcount != 6 || ln_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_valid_hold got=%0d cycles,valid_after=%b want=6,0", vcount, ln_cmd_valid);
        end
        wait_done(100, got, at);
        checks++;
        if (!got || err !== 1'b0 || rows_done !== 16'd1 || hs_count - hs0 != 1) begin
            failures++;
            $display("FAIL bp_status got=%b err=%b rows=%0d accepts=%0d want 1/0/1/1", got, err, rows_done, hs_count - hs0);
        end
        while (rd_idx < hs_count) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL bp_cmd extra got=%h want=none", obs[rd_idx % 256]);
            end else begin
                e = sb.pop_front();
                if (obs[rd_idx % 256] !== e) begin
                    failures++;
                    $display("FAIL bp_cmd got=%h want=%h", obs[rd_idx % 256], e);
                end
            end
            rd_idx++;
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_zero_batch();
        int acc, hs0;
        logic [15:0] rows_v[2];
        logic [15:0] len_v[2];
        rows_v[0] = 16'd0; len_v[0] = 16'd8;
        rows_v[1] = 16'd4; len_v[1] = 16'd0;
        for (int k = 0; k < 2; k++) begin
            hs0 = hs_count;
            ln_cmd_ready = 1'b1;
            send_batch(rows_v[k], len_v[k], 16'h0100, 16'h0010, 16'h0200, 16'h0010, 16'h0300, 16'h0310, acc);
            checks++;
            if ({done, err, ln_cmd_valid} !== 3'b110) begin
                failures++;
                $display("FAIL zero%0d_done got=%b want=110 (done,err,valid)", k, {done, err, ln_cmd_valid});
            end
            @(negedge clk);
            checks++;
            if ({done, err, ln_cmd_valid, batch_ready} !== 4'b0101 || rows_done !== 16'd0) begin
                failures++;
                $display("FAIL zero%0d_after got=%b rows=%0d want=0101 rows=0", k, {done, err, ln_cmd_valid, batch_ready}, rows_done);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (err !== 1'b1 || hs_count != hs0) begin
                failures++;
                $display("FAIL zero%0d_hold err=%b cmds=%0d want 1/0", k, err, hs_count - hs0);
            end
        end
        sb.delete();
    endtask

    task automatic test_wrap_and_stale();
        int   acc, at, hs0;
        bit   got;
        cmd_t e;
        hs0 = hs_count;
        eng_delay = 1;
        ln_cmd_ready = 1'b0;
        send_batch(16'd2, 16'd4, 16'hFFF0, 16'h0010, 16'hFFE0, 16'h0040, 16'h0C00, 16'h0D00, acc);
        inject_req++;
        @(negedge clk);
        checks++;
        if ({ln_cmd_valid, done, busy} !== 3'b101 || rows_done !== 16'd0) begin
            failures++;
            $display("FAIL stale_done got=%b rows=%0d want=101 rows=0", {ln_cmd_valid, done, busy}, rows_done);
        end
        ln_cmd_ready = 1'b1;
        wait_done(100, got, at);
        checks++;
        if (!got || err !== 1'b0 || rows_done !== 16'd2) begin
            failures++;
            $display("FAIL wrap_status got=%b err=%b rows=%0d want 1/0/2", got, err, rows_done);
        end
        checks++;
        if (hs_count - hs0 != 2 || obs[(hs0 + 1) % 256].src !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_src got=%h cmds=%0d want=0000 cmds=2", obs[(hs0 + 1) % 256].src, hs_count - hs0);
        end
        while (rd_idx < hs_count) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL wrap_cmd extra got=%h want=none", obs[rd_idx % 256]);
            end else begin
                e = sb.pop_front();
                if (obs[rd_idx % 256] !== e) begin
                    failures++;
                    $display("FAIL wrap_cmd got=%h want=%h", obs[rd_idx % 256], e);
                end
            end
            rd_idx++;
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        int   acc, at, hs0;
        bit   got;
        cmd_t e;
        hs0 = hs_count;
        eng_hang = 1'b1;
        ln_cmd_ready = 1'b1;
        send_batch(16'd2, 16'd8, 16'h0600, 16'h0010, 16'h0700, 16'h0010, 16'h0E00, 16'h0F00, acc);
        wait_done(200, got, at);
        checks++;
        if (!got || hs_count - hs0 != 1) begin
            failures++;
            $display("FAIL wdog_fire got=%b cmds=%0d want 1/1", got, hs_count - hs0);
        end else begin
            checks++;
            if (at != hs_cyc[hs0 % 256] + 1 + 64) begin
                failures++;
                $display("FAIL wdog_latency got=%0d want=%0d", at - hs_cyc[hs0 % 256] - 1, 64);
            end
        end
        checks++;
        if (err !== 1'b1 || rows_done !== 16'd0) begin
            failures++;
            $display("FAIL wdog_status err=%b rows=%0d want 1/0", err, rows_done);
        end
        if (rd_idx < hs_count && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[rd_idx % 256] !== e) begin
                failures++;
                $display("FAIL wdog_cmd got=%h want=%h", obs[rd_idx % 256], e);
            end
        end
        rd_idx = hs_count;
        sb.delete();
        eng_hang = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_batch();
        int   acc, at, hs0;
        bit   got;
        cmd_t e;
        hs0 = hs_count;
        eng_delay = 20;
        ln_cmd_ready = 1'b1;
        send_batch(16'd3, 16'd8, 16'h1000, 16'h0100, 16'h1800, 16'h0100, 16'h0E10, 16'h0F10, acc);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (hs_count >= hs0 + 2) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rstmid_row1 got=%0d cmds want=2", hs_count - hs0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ln_cmd_valid, done, err, busy, batch_ready} !== 5'b00001 || rows_done !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b rows=%0d want=00001 rows=0", {ln_cmd_valid, done, err, busy, batch_ready}, rows_done);
        end
        checks++;
        if ({ln_length, ln_src_base, ln_dst_base, ln_gamma_base, ln_beta_base} !== 80'd0) begin
            failures++;
            $display("FAIL rstmid_payload got=%h want=0", {ln_length, ln_src_base, ln_dst_base, ln_gamma_base, ln_beta_base});
        end
        while (rd_idx < hs_count && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[rd_idx % 256] !== e) begin
                failures++;
                $display("FAIL rstmid_cmd got=%h want=%h", obs[rd_idx % 256], e);
            end
            rd_idx++;
        end
        rd_idx = hs_count;
        sb.delete();
        hs0 = hs_count;
        eng_delay = 2;
        send_batch(16'd1, 16'd4, 16'h3000, 16'h0010, 16'h3800, 16'h0010, 16'h0A10, 16'h0B10, acc);
        wait_done(100, got, at);
        checks++;
        if (!got || err !== 1'b0 || rows_done !== 16'd1 || hs_count - hs0 != 1) begin
            failures++;
            $display("FAIL rstmid_new got=%b err=%b rows=%0d cmds=%0d want 1/0/1/1", got, err, rows_done, hs_count - hs0);
        end
        while (rd_idx < hs_count) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rstmid_new_cmd extra got=%h want=none", obs[rd_idx % 256]);
            end else begin
                e = sb.pop_front();
                if (obs[rd_idx % 256] !== e) begin
                    failures++;
                    $display("FAIL rstmid_new_cmd got=%h want=%h", obs[rd_idx % 256], e);
                end
            end
            rd_idx++;
        end
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        rst              = 1'b1;
        batch_valid      = 1'b0;
        ln_cmd_ready     = 1'b0;
        batch_rows       = '0;
        batch_length     = '0;
        batch_src_base   = '0;
        batch_src_stride = '0;
        batch_dst_base   = '0;
        batch_dst_stride = '0;
        batch_gamma_base = '0;
        batch_beta_base  = '0;
        @(negedge clk);
        test_reset();
        test_multi_row();
        test_backpressure();
        test_zero_batch();
        test_wrap_and_stale();
        test_watchdog();
        test_reset_mid_batch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
